// File: rtl/lot_gate_arbiter_pkg.sv
// Shared definitions for the parking-lot gate: state encoding, lane identity,
// default sizing constants (also used by the display logic) and the
// round-robin tie-break helper.
package lot_pkg;

  // Default sizing shared with the occupancy display logic.
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_CAPACITY     = 100;
  localparam int DEF_OPEN_TIMEOUT = 16;

  // Gate controller state encoding.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT_IN  = 2'd1;
  localparam logic [1:0] ST_GRANT_OUT = 2'd2;
  localparam logic [1:0] ST_CLOSE     = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    GRANT_IN  = ST_GRANT_IN,
    GRANT_OUT = ST_GRANT_OUT,
    CLOSE     = ST_CLOSE
  } state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

  // Decides whether the entry lane wins arbitration. With both lanes
  // eligible the lane that did not own the gate last time wins.
  function automatic logic entry_wins(input logic entry_ok,
                                      input logic exit_ok,
                                      input lane_t rr_last);
    logic win;
    if (entry_ok && exit_ok) begin
      win = (rr_last == LANE_EXIT);
    end else begin
      win = entry_ok;
    end
    return win;
  endfunction

endpackage

// File: rtl/lot_gate_arbiter_if.sv
// Lane/gate handshake bundle between the sensor FSMs, the gate arbiter and
// the display logic.
//   entry_req/exit_req     level requests from the lane sensors
//   entry_done/exit_done   1-cycle pass pulses from the lane FSMs
//   gate_open, entry_grant, exit_grant, count, full, empty, timeout_evt
//                          arbiter outputs
// Modports: master = sensor/display side, slave = gate arbiter.
interface lot_gate_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             entry_req;
  logic             exit_req;
  logic             entry_done;
  logic             exit_done;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             timeout_evt;

  modport master (
    output entry_req, exit_req, entry_done, exit_done,
    input  gate_open, entry_grant, exit_grant, count, full, empty, timeout_evt
  );

  modport slave (
    input  entry_req, exit_req, entry_done, exit_done,
    output gate_open, entry_grant, exit_grant, count, full, empty, timeout_evt
  );
endinterface

// File: rtl/lot_gate_arbiter_timer.sv
// Grant hold-time counter for the gate arbiter.
//   clk     system clock
//   reset   asynchronous active-low reset
//   clear   forces the count to zero (held while no lane owns the gate)
//   enable  advances the count by one per cycle
//   expire  high while the count sits at OPEN_TIMEOUT-1
module gate_timer #(
  parameter int OPEN_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int TW = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST_C = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] ONE_C  = TW'(1);

  logic [TW-1:0] cnt_r;

  // Hold-time counter: clear wins over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {TW{1'b0}};
    end else if (clear) begin
      cnt_r <= {TW{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == LAST_C);
endmodule

// File: rtl/lot_gate_arbiter.sv
// Shared barrier-gate arbiter for the parking lot. Grants the gate to the
// entry or exit lane, holds it until the owning lane reports a pass or the
// hold timer expires, closes for one cycle, and owns the occupancy count.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    slave side of lot_gate_arbiter_if (requests, pass pulses, gate
//          grants, occupancy count, full/empty flags, timeout pulse)
module lot_gate_arbiter
  import lot_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT
) (
  input logic            clk,
  input logic            reset,
  lot_gate_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_r, state_nxt_s;
  lane_t            rr_last_r, rr_last_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             gate_open_r, entry_grant_r, exit_grant_r, timeout_evt_r;
  logic             timeout_nxt_s;
  logic             full_s, empty_s, entry_ok_s, exit_ok_s;
  logic             timer_en_s, timer_clear_s, timer_expire_s;

  assign full_s     = (count_r == CAP_C);
  assign empty_s    = (count_r == ZERO_C);
  assign entry_ok_s = bus.entry_req && !full_s;
  assign exit_ok_s  = bus.exit_req;

  // The timer only runs while a lane owns the gate, so it is already zero
  // on the first granted cycle.
  assign timer_en_s    = (state_r == GRANT_IN) || (state_r == GRANT_OUT);
  assign timer_clear_s = !timer_en_s;

  gate_timer #(
    .OPEN_TIMEOUT(OPEN_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear_s),
    .enable(timer_en_s),
    .expire(timer_expire_s)
  );

  // Next-state, arbitration and occupancy update.
  always_comb begin
    state_nxt_s   = state_r;
    rr_last_nxt_s = rr_last_r;
    count_nxt_s   = count_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (entry_ok_s || exit_ok_s) begin
          if (entry_wins(entry_ok_s, exit_ok_s, rr_last_r)) begin
            state_nxt_s = GRANT_IN;
          end else begin
            state_nxt_s = GRANT_OUT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_IN: begin
        // A pass on the last timer cycle beats the timeout.
        if (bus.entry_done) begin
          if (count_r < CAP_C) begin
            count_nxt_s = count_r + ONE_C;
          end else begin
            count_nxt_s = count_r;
          end
          rr_last_nxt_s = LANE_ENTRY;
          state_nxt_s   = CLOSE;
        end else if (timer_expire_s) begin
          timeout_nxt_s = 1'b1;
          rr_last_nxt_s = LANE_ENTRY;
          state_nxt_s   = CLOSE;
        end else begin
          state_nxt_s = GRANT_IN;
        end
      end
      GRANT_OUT: begin
        if (bus.exit_done) begin
          if (count_r != ZERO_C) begin
            count_nxt_s = count_r - ONE_C;
          end else begin
            count_nxt_s = count_r;
          end
          rr_last_nxt_s = LANE_EXIT;
          state_nxt_s   = CLOSE;
        end else if (timer_expire_s) begin
          timeout_nxt_s = 1'b1;
          rr_last_nxt_s = LANE_EXIT;
          state_nxt_s   = CLOSE;
        end else begin
          state_nxt_s = GRANT_OUT;
        end
      end
      CLOSE: begin
        // Requests are deliberately not looked at here.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, occupancy and registered gate outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      rr_last_r     <= LANE_EXIT;
      count_r       <= ZERO_C;
      gate_open_r   <= 1'b0;
      entry_grant_r <= 1'b0;
      exit_grant_r  <= 1'b0;
      timeout_evt_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rr_last_r     <= rr_last_nxt_s;
      count_r       <= count_nxt_s;
      gate_open_r   <= (state_nxt_s == GRANT_IN) || (state_nxt_s == GRANT_OUT);
      entry_grant_r <= (state_nxt_s == GRANT_IN);
      exit_grant_r  <= (state_nxt_s == GRANT_OUT);
      timeout_evt_r <= timeout_nxt_s;
    end
  end

  assign bus.gate_open   = gate_open_r;
  assign bus.entry_grant = entry_grant_r;
  assign bus.exit_grant  = exit_grant_r;
  assign bus.count       = count_r;
  assign bus.full        = full_s;
  assign bus.empty       = empty_s;
  assign bus.timeout_evt = timeout_evt_r;
endmodule

// File: tb/tb_lot_gate_arbiter.sv
// Self-checking bench for lot_gate_arbiter (CAPACITY=3, OPEN_TIMEOUT=8).
// A lane-ownership reference model is stepped every clock; a hand-derived
// vector table and directed sequences add explicit expectations.
module tb_lot_gate_arbiter;
  localparam int CAP = 3;
  localparam int OT  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  lot_gate_arbiter_if #(.CNT_W(8)) bus ();

  lot_gate_arbiter #(.CNT_W(8), .CAPACITY(CAP), .OPEN_TIMEOUT(OT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the gate, how long it has been held,
  // whether the gate is in its one-cycle cool-down, and the occupancy.
  int m_count, m_owner, m_held, m_last;  // owner/last: 0 none, 1 entry, 2 exit
  bit m_cool, m_tevt;

  typedef struct {
    logic er, xr, ed, xd;
    logic eg, xg;
    int   cnt;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string tag, input string what, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_owner = 0; m_held = 0; m_last = 2; m_cool = 0; m_tevt = 0;
  endtask

  task automatic model_step();
    bit ein, xin;
    if (!reset) begin
      model_reset();
      return;
    end
    m_tevt = 0;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_owner == 0) begin
      ein = bus.entry_req && (m_count < CAP);
      xin = bus.exit_req;
      if (ein && xin) m_owner = (m_last == 2) ? 1 : 2;
      else if (ein) m_owner = 1;
      else if (xin) m_owner = 2;
      m_held = 0;
    end else begin
      m_held++;
      if (m_owner == 1 && bus.entry_done) begin
        m_count = (m_count < CAP) ? m_count + 1 : CAP;
        m_last = 1; m_owner = 0; m_cool = 1;
      end else if (m_owner == 2 && bus.exit_done) begin
        m_count = (m_count > 0) ? m_count - 1 : 0;
        m_last = 2; m_owner = 0; m_cool = 1;
      end else if (m_held >= OT) begin
        m_tevt = 1; m_last = m_owner; m_owner = 0; m_cool = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk(tag, "gate_open",   int'(bus.gate_open),   int'(m_owner != 0));
    chk(tag, "entry_grant", int'(bus.entry_grant), int'(m_owner == 1));
    chk(tag, "exit_grant",  int'(bus.exit_grant),  int'(m_owner == 2));
    chk(tag, "count",       int'(bus.count),       m_count);
    chk(tag, "full",        int'(bus.full),        int'(m_count == CAP));
    chk(tag, "empty",       int'(bus.empty),       int'(m_count == 0));
    chk(tag, "timeout_evt", int'(bus.timeout_evt), int'(m_tevt));
  endtask

  // One clock: model consumes the inputs, DUT is sampled 1 time unit later.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic set_in(input logic er, input logic xr, input logic ed, input logic xd);
    bus.entry_req = er; bus.exit_req = xr; bus.entry_done = ed; bus.exit_done = xd;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    tick("rst"); tick("rst");
    reset = 1'b1;
  endtask

  // Request, pass and close for one lane (lane 1 entry, 2 exit).
  task automatic do_pass(input int lane);
    if (lane == 1) set_in(1'b1, 1'b0, 1'b0, 1'b0); else set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick("pass_req");
    if (lane == 1) set_in(1'b0, 1'b0, 1'b1, 1'b0); else set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick("pass_done");
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick("pass_close");
  endtask

  task automatic set_vec(input int i, input logic er, input logic xr, input logic ed,
                         input logic xd, input logic eg, input logic xg, input int cnt);
    tbl[i].er = er; tbl[i].xr = xr; tbl[i].ed = ed; tbl[i].xd = xd;
    tbl[i].eg = eg; tbl[i].xg = xg; tbl[i].cnt = cnt;
  endtask

  initial begin
    //          er    xr    ed    xd    eg    xg   cnt
    set_vec(0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    set_vec(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    set_vec(2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    set_vec(3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    set_vec(4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    set_vec(5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    set_vec(6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    set_vec(7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    set_vec(8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    set_vec(9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    set_vec(10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    set_vec(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    set_vec(12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    set_vec(13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    set_vec(14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    set_vec(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    set_vec(16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    set_vec(17, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    set_vec(18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Reset held for two cycles with both lanes requesting.
    model_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    tick("reset_hold");
    chk("reset_hold", "empty_flag", int'(bus.empty), 1);
    tick("reset_hold");
    reset = 1'b1;
    chk("release", "no_grant_yet", int'(bus.entry_grant | bus.exit_grant), 0);
    tick("first_tie");
    chk("first_tie", "entry_wins", int'(bus.entry_grant), 1);

    // Async reset while granted, then the vector table from a clean state.
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].er, tbl[i].xr, tbl[i].ed, tbl[i].xd);
      tick("table");
      chk($sformatf("vec%0d", i), "entry_grant", int'(bus.entry_grant), int'(tbl[i].eg));
      chk($sformatf("vec%0d", i), "exit_grant",  int'(bus.exit_grant),  int'(tbl[i].xg));
      chk($sformatf("vec%0d", i), "gate_open",   int'(bus.gate_open),   int'(tbl[i].eg | tbl[i].xg));
      chk($sformatf("vec%0d", i), "count",       int'(bus.count),       tbl[i].cnt);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);

    // Round-robin ties starting from count=1 with exit as last owner.
    do_reset();
    do_pass(1); do_pass(1); do_pass(2);
    chk("tie_setup", "count", int'(bus.count), 1);
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    tick("tie1");
    chk("tie1", "entry_grant", int'(bus.entry_grant), 1);
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    tick("both_done");
    chk("both_done", "count_plus_one", int'(bus.count), 2);
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    tick("tie_close");
    tick("tie2");
    chk("tie2", "exit_grant", int'(bus.exit_grant), 1);
    set_in(1'b1, 1'b1, 1'b0, 1'b1);
    tick("tie2_done");
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    tick("tie2_close");
    tick("tie3");
    chk("tie3", "entry_grant", int'(bus.entry_grant), 1);
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    tick("tie3_done");
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick("tie3_close");

    // Timeout with the request dropped right after the grant.
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick("to_grant");
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < OT; i++) begin
      tick("to_hold");
      chk("to_hold", "still_granted", int'(bus.entry_grant), 1);
    end
    tick("to_fire");
    chk("to_fire", "timeout_evt", int'(bus.timeout_evt), 1);
    chk("to_fire", "count_kept", int'(bus.count), 2);
    tick("to_after");
    chk("to_after", "single_pulse", int'(bus.timeout_evt), 0);

    // Pass pulse on the timeout cycle: the pass wins.
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick("tod_grant");
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < OT; i++) tick("tod_hold");
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    tick("tod_done");
    chk("tod_done", "timeout_evt", int'(bus.timeout_evt), 0);
    chk("tod_done", "count", int'(bus.count), 3);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick("tod_close");

    // Underflow, stray pulses and async reset during an exit grant.
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    tick("stray"); tick("stray");
    chk("stray", "count", int'(bus.count), 0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick("exit_zero");
    chk("exit_zero", "exit_grant", int'(bus.exit_grant), 1);
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick("underflow");
    chk("underflow", "count", int'(bus.count), 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick("uf_close");
    do_pass(1);
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick("rst_mid_grant");
    chk("rst_mid_grant", "exit_grant", int'(bus.exit_grant), 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst", "gate_open", int'(bus.gate_open), 0);
    chk("async_rst", "count", int'(bus.count), 0);
    tick("async_rst_hold");
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick("async_rst_rel");

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      set_in(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 2) != 0),
             logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 4) == 0));
      tick("random");
      chk("random", "grant_exclusive", int'(bus.entry_grant & bus.exit_grant), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
